// File: rtl/dm_arbiter.sv
// dm_arbiter: arbitrates two requesters onto one 32-bit data memory port.
// Sub-word stores are performed as a read-modify-write of the addressed word.
module dm_arbiter #(
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wd0,
  input  logic [31:0] i_wd1,
  input  logic [3:0]  i_be0,
  input  logic [3:0]  i_be1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_rvalid0,
  output logic        o_rvalid1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic        o_mem_wen,
  output logic        o_mem_ren,
  input  logic [31:0] i_mem_rd
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RMW_RD,
    RMW_WR
  } state_t;

  state_t         state;
  logic           ptr;
  logic           owner;
  logic           sel1;
  logic           accept;
  logic           req_we;
  logic [DW-1:0]  req_addr;
  logic [DW-1:0]  req_wd;
  logic [BW-1:0]  req_be;
  logic [DW-1:0]  wd_q;
  logic [BW-1:0]  be_q;
  logic [DW-1:0]  merged;

  // Winner selection and request mux; grants are only issued from IDLE
  always_comb begin
    sel1 = 1'b0;
    if (PRIO_FIXED != 0) begin
      sel1 = ~i_req0 & i_req1;
    end else begin
      sel1 = i_req1 & (~i_req0 | ptr);
    end
    accept   = i_rst_n & (state == IDLE) & (i_req0 | i_req1);
    req_we   = sel1 ? i_we1   : i_we0;
    req_addr = sel1 ? i_addr1 : i_addr0;
    req_wd   = sel1 ? i_wd1   : i_wd0;
    req_be   = sel1 ? i_be1   : i_be0;
  end

  assign o_gnt0 = accept & ~sel1;
  assign o_gnt1 = accept & sel1;

  // Lane merge of the latched store data over the word read back from memory
  always_comb begin
    merged = i_mem_rd;
    for (int unsigned n = 0; n < BW; n++) begin
      if (be_q[n]) begin
        merged[8*n +: 8] = wd_q[8*n +: 8];
      end
    end
  end

  // Access sequencer with registered memory strobes and read-return outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      wd_q       <= '0;
      be_q       <= '0;
      o_rvalid0  <= 1'b0;
      o_rvalid1  <= 1'b0;
      o_rdata0   <= '0;
      o_rdata1   <= '0;
      o_mem_addr <= '0;
      o_mem_wd   <= '0;
      o_mem_wen  <= 1'b0;
      o_mem_ren  <= 1'b0;
    end else begin
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
      o_mem_wen <= 1'b0;
      o_mem_ren <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= sel1;
            wd_q  <= req_wd;
            be_q  <= req_be;
            if (PRIO_FIXED == 0) begin
              ptr <= ~sel1;
            end
            if (!req_we) begin
              state      <= READ;
              o_mem_addr <= req_addr;
              o_mem_ren  <= 1'b1;
            end else if (req_be == {BW{1'b1}}) begin
              state      <= WRITE;
              o_mem_addr <= req_addr;
              o_mem_wd   <= req_wd;
              o_mem_wen  <= 1'b1;
            end else if (req_be != '0) begin
              state      <= RMW_RD;
              o_mem_addr <= req_addr;
              o_mem_ren  <= 1'b1;
            end
          end
        end
        READ: begin
          if (owner) begin
            o_rdata1  <= i_mem_rd;
            o_rvalid1 <= 1'b1;
          end else begin
            o_rdata0  <= i_mem_rd;
            o_rvalid0 <= 1'b1;
          end
          state <= IDLE;
        end
        WRITE: begin
          state <= IDLE;
        end
        RMW_RD: begin
          o_mem_wd  <= merged;
          o_mem_wen <= 1'b1;
          state     <= RMW_WR;
        end
        RMW_WR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed table, corner sequences and randomized model check for dm_arbiter.
module tb_dm_arbiter;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        rst_n;
  logic        req [2];
  logic        we  [2];
  logic [31:0] addr[2];
  logic [31:0] wd  [2];
  logic [3:0]  be  [2];

  logic        g0, g1, rv0, rv1, mwen, mren;
  logic [31:0] rd0, rd1, maddr, mwd, mrd;
  logic        fg0, fg1, frv0, frv1, fmwen, fmren;
  logic [31:0] frd0, frd1, fmaddr, fmwd;

  // Round-robin instance with a behavioural memory
  dm_arbiter #(.PRIO_FIXED(0)) dut (
    .i_clk(i_clk), .i_rst_n(rst_n),
    .i_req0(req[0]), .i_req1(req[1]), .i_we0(we[0]), .i_we1(we[1]),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_wd0(wd[0]), .i_wd1(wd[1]),
    .i_be0(be[0]), .i_be1(be[1]),
    .o_gnt0(g0), .o_gnt1(g1), .o_rvalid0(rv0), .o_rvalid1(rv1),
    .o_rdata0(rd0), .o_rdata1(rd1),
    .o_mem_addr(maddr), .o_mem_wd(mwd), .o_mem_wen(mwen), .o_mem_ren(mren),
    .i_mem_rd(mrd)
  );

  // Fixed-priority instance on the same request inputs, memory reads as zero
  dm_arbiter #(.PRIO_FIXED(1)) dut_fp (
    .i_clk(i_clk), .i_rst_n(rst_n),
    .i_req0(req[0]), .i_req1(req[1]), .i_we0(we[0]), .i_we1(we[1]),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_wd0(wd[0]), .i_wd1(wd[1]),
    .i_be0(be[0]), .i_be1(be[1]),
    .o_gnt0(fg0), .o_gnt1(fg1), .o_rvalid0(frv0), .o_rvalid1(frv1),
    .o_rdata0(frd0), .o_rdata1(frd1),
    .o_mem_addr(fmaddr), .o_mem_wd(fmwd), .o_mem_wen(fmwen), .o_mem_ren(fmren),
    .i_mem_rd(32'h0)
  );

  // Word memory: combinational read, synchronous write, plus bench preload/clear
  logic [31:0] mem [64];
  logic        mem_clr;
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  always @(posedge i_clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (mwen) begin
      mem[maddr[7:2]] <= mwd;
    end
  end
  assign mrd = mem[maddr[7:2]];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Wait for the sampling edge and check the always-on invariants
  task automatic at_neg();
    @(negedge i_clk);
    if (rst_n) begin
      check("excl", 256'({mwen & mren, g0 & g1, fmwen & fmren, fg0 & fg1}), 256'(4'b0000));
    end
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wd[k] = '0; be[k] = '0;
    end
  endtask

  task automatic do_reset(input bit clr);
    rst_n = 1'b0;
    idle_inputs();
    mem_clr = clr;
    @(posedge i_clk); #1;
    mem_clr = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(posedge i_clk); #1;
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge i_clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic new_txn(input int k);
    int unsigned s;
    req[k]  = 1'b1;
    we[k]   = 1'($urandom_range(0, 1));
    addr[k] = 32'($urandom_range(0, 15)) << 2;
    wd[k]   = $urandom;
    s = $urandom_range(0, 3);
    if (s == 0)      be[k] = 4'hF;
    else if (s == 1) be[k] = 4'h0;
    else             be[k] = 4'($urandom_range(1, 14));
  endtask

  typedef struct {
    logic        k;
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [5:0]  flags;   // {gnt0, gnt1, rvalid0, rvalid1, ren, wen}
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rv_t;

  vec_t tbl[15];

  // Reference model state for the randomized phase
  logic [7:0]  ref_mem[64];
  rv_t         rvq0[$];
  rv_t         rvq1[$];
  bit          s_ren[8];
  bit          s_wen[8];
  logic [31:0] s_addr[8];
  logic [31:0] s_wd[8];

  initial begin
    int grr[$];
    int gfp[$];
    int exp_rr[4];
    int free_at;
    int ptr_m;
    logic [31:0] last0, last1;

    rst_n = 1'b0; mem_clr = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    idle_inputs();

    // Reset state, with requests present: grants must stay low under reset
    mem_clr = 1'b1;
    @(posedge i_clk); #1;
    mem_clr = 1'b0;
    req[0] = 1'b1; req[1] = 1'b1;
    @(negedge i_clk);
    check("reset_state",
          256'({g0, g1, rv0, rv1, mwen, mren, fg0, fg1, rd0, rd1, maddr, mwd}), 256'(0));
    idle_inputs();
    @(negedge i_clk);
    rst_n = 1'b1;
    preload(6'd5, 32'h11223344);

    // Directed table: full write, back-to-back reads, partial write, be=0 write
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 6'b100000, 32'h00, 32'h0,        32'h0,        32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        4'h0, 6'b000001, 32'h10, 32'hDEADBEEF, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 6'b100000, 32'h10, 32'hDEADBEEF, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 6'b000010, 32'h10, 32'hDEADBEEF, 32'h0,        32'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 6'b101000, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        4'h0, 6'b000010, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        4'h0, 6'b001000, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h14, 32'hAABBCCDD, 4'h5, 6'b010000, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        4'h0, 6'b000010, 32'h14, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        4'h0, 6'b000001, 32'h14, 32'h11BB33DD, 32'hDEADBEEF, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h18, 32'h55555555, 4'h0, 6'b100000, 32'h14, 32'h11BB33DD, 32'hDEADBEEF, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        4'h0, 6'b000000, 32'h14, 32'h11BB33DD, 32'hDEADBEEF, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h14, 32'h0,        4'h0, 6'b010000, 32'h14, 32'h11BB33DD, 32'hDEADBEEF, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        4'h0, 6'b000010, 32'h14, 32'h11BB33DD, 32'hDEADBEEF, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        4'h0, 6'b000100, 32'h14, 32'h11BB33DD, 32'hDEADBEEF, 32'h11BB33DD};

    for (int i = 0; i < 15; i++) begin
      @(posedge i_clk); #1;
      idle_inputs();
      req[tbl[i].k]  = tbl[i].r;
      we[tbl[i].k]   = tbl[i].w;
      addr[tbl[i].k] = tbl[i].a;
      wd[tbl[i].k]   = tbl[i].d;
      be[tbl[i].k]   = tbl[i].b;
      at_neg();
      check($sformatf("table[%0d]", i),
            256'({g0, g1, rv0, rv1, mren, mwen, maddr, mwd, rd0, rd1}),
            256'({tbl[i].flags, tbl[i].maddr, tbl[i].mwd, tbl[i].rd0, tbl[i].rd1}));
    end

    // Contention: both hold read requests continuously from reset
    do_reset(1'b0);
    @(posedge i_clk); #1;
    req[0] = 1'b1; addr[0] = 32'h10;
    req[1] = 1'b1; addr[1] = 32'h10;
    for (int cyc = 0; cyc < 8; cyc++) begin
      at_neg();
      if (g0)  grr.push_back(0);
      if (g1)  grr.push_back(1);
      if (fg0) gfp.push_back(0);
      if (fg1) gfp.push_back(1);
      check("cont_rvalid", 256'({rv0, rv1, frv0, frv1}),
            256'({cyc == 2 || cyc == 6, cyc == 4, cyc >= 2 && cyc % 2 == 0, 1'b0}));
      check("cont_fp_rdata", 256'({frd0, frd1}), 256'(0));
    end
    exp_rr = '{0, 1, 0, 1};
    check("cont_rr_count", 256'(grr.size()), 256'(4));
    check("cont_fp_count", 256'(gfp.size()), 256'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < grr.size()) check($sformatf("cont_rr[%0d]", i), 256'(grr[i]), 256'(exp_rr[i]));
      if (i < gfp.size()) check($sformatf("cont_fp[%0d]", i), 256'(gfp[i]), 256'(0));
    end
    check("cont_fp_mem", 256'({fmaddr, fmwd}), 256'({32'h10, 32'h0}));
    @(posedge i_clk); #1;
    idle_inputs();
    repeat (3) at_neg();

    // Reset asserted while the merged word is being written
    preload(6'd6, 32'hCAFEF00D);
    @(posedge i_clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h18; wd[0] = 32'h12345678; be[0] = 4'h3;
    at_neg();
    check("rmw_gnt", 256'({g0, g1}), 256'(2'b10));
    @(posedge i_clk); #1;
    idle_inputs();
    at_neg();
    check("rmw_rd_phase", 256'({mren, mwen}), 256'(2'b10));
    @(posedge i_clk); #1;
    at_neg();
    check("rmw_wr_phase", 256'({mren, mwen, mwd}), 256'({2'b01, 32'hCAFE5678}));
    #1 rst_n = 1'b0;
    #1;
    check("reset_abort",
          256'({mwen, mren, g0, g1, rv0, rv1, rd0, rd1, maddr, mwd}), 256'(0));
    @(posedge i_clk);
    @(negedge i_clk);
    rst_n = 1'b1;
    check("no_replay", 256'(mem[6]), 256'(32'hCAFEF00D));
    @(posedge i_clk); #1;
    req[0] = 1'b1; addr[0] = 32'h18;
    req[1] = 1'b1; addr[1] = 32'h18;
    at_neg();
    check("ptr_after_reset", 256'({g0, g1, rv0, rv1}), 256'(4'b1000));
    @(posedge i_clk); #1;
    req[0] = 1'b0;
    at_neg();
    check("post_reset_read", 256'({g0, g1, rv0, rv1, mren}), 256'(5'b00001));
    @(posedge i_clk); #1;
    at_neg();
    check("post_reset_rvalid", 256'({g0, g1, rv0, rv1, rd0}), 256'({4'b0110, 32'hCAFEF00D}));
    @(posedge i_clk); #1;
    idle_inputs();
    repeat (3) at_neg();

    // Randomized traffic against the transaction-level model
    do_reset(1'b1);
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      s_ren[i] = 1'b0; s_wen[i] = 1'b0; s_addr[i] = '0; s_wd[i] = '0;
    end
    rvq0.delete(); rvq1.delete();
    free_at = 0; ptr_m = 0; last0 = '0; last1 = '0;
    @(posedge i_clk); #1;
    new_txn(0);
    new_txn(1);

    for (int c = 0; c < 1500; c++) begin
      int          wn;
      int          sl;
      int          base;
      bit          e0, e1;
      logic [31:0] cur;
      at_neg();
      sl = c % 8;

      e0 = (rvq0.size() > 0) && (rvq0[0].cyc == c);
      e1 = (rvq1.size() > 0) && (rvq1[0].cyc == c);
      if (e0) begin last0 = rvq0[0].data; void'(rvq0.pop_front()); end
      if (e1) begin last1 = rvq1[0].data; void'(rvq1.pop_front()); end

      wn = -1;
      if (c >= free_at && (req[0] || req[1])) begin
        if (req[0] && req[1]) wn = ptr_m;
        else                  wn = req[1] ? 1 : 0;
        ptr_m = 1 - wn;
      end

      check("rnd_gnt", 256'({g0, g1}), 256'({wn == 0, wn == 1}));
      check("rnd_rvalid", 256'({rv0, rv1}), 256'({e0, e1}));
      check("rnd_rdata0", 256'(rd0), 256'(last0));
      check("rnd_rdata1", 256'(rd1), 256'(last1));
      check("rnd_mem_ctl", 256'({mren, mwen}), 256'({s_ren[sl], s_wen[sl]}));
      if (s_ren[sl] || s_wen[sl]) check("rnd_mem_addr", 256'(maddr), 256'(s_addr[sl]));
      if (s_wen[sl]) check("rnd_mem_wd", 256'(mwd), 256'(s_wd[sl]));
      s_ren[sl] = 1'b0; s_wen[sl] = 1'b0;

      if (wn >= 0) begin
        base = int'(addr[wn][5:0]);
        cur  = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        if (!we[wn]) begin
          free_at = c + 2;
          s_ren[(c+1)%8] = 1'b1; s_addr[(c+1)%8] = addr[wn];
          if (wn == 0) rvq0.push_back('{c + 2, cur});
          else         rvq1.push_back('{c + 2, cur});
        end else if (be[wn] == 4'h0) begin
          free_at = c + 1;
        end else begin
          for (int n = 0; n < 4; n++) begin
            if (be[wn][n]) ref_mem[base+n] = wd[wn][8*n +: 8];
          end
          cur = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
          if (be[wn] == 4'hF) begin
            free_at = c + 2;
            s_wen[(c+1)%8] = 1'b1; s_addr[(c+1)%8] = addr[wn]; s_wd[(c+1)%8] = cur;
          end else begin
            free_at = c + 3;
            s_ren[(c+1)%8] = 1'b1; s_addr[(c+1)%8] = addr[wn];
            s_wen[(c+2)%8] = 1'b1; s_addr[(c+2)%8] = addr[wn]; s_wd[(c+2)%8] = cur;
          end
        end
      end

      @(posedge i_clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (wn == k) begin
          if ($urandom_range(0, 1) == 0) new_txn(k);
          else req[k] = 1'b0;
        end else if (req[k]) begin
          if ($urandom_range(0, 31) == 0) req[k] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          new_txn(k);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL arbitrate two requesters onto one byte-addressed, 32-bit-word data memory port (combinational read, synchronous write) and SHALL perform sub-word stores by read-modify-write.
REQ-002 Parameter PRIO_FIXED, default 0: 0 selects round-robin, 1 gives requester 0 absolute priority.
REQ-003 i_clk  in  1  sole clock, all state updates on rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_req0 / i_req1  in  1  request from requester k, held until granted.
REQ-006 i_we0 / i_we1  in  1  1 = write, 0 = read.
REQ-007 i_addr0 / i_addr1  in  32  byte address, passed to memory unmodified.
REQ-008 i_wd0 / i_wd1  in  32  write data; lane n = bits [8n+7:8n].
REQ-009 i_be0 / i_be1  in  4  write byte enables, bit n enables lane n; ignored for reads.
REQ-010 o_gnt0 / o_gnt1  out  1  one-cycle accept pulse.
REQ-011 o_rvalid0 / o_rvalid1  out  1  one-cycle read-data-valid pulse.
REQ-012 o_rdata0 / o_rdata1  out  32  read data for requester k.
REQ-013 o_mem_addr  out  32;  o_mem_wd  out  32;  o_mem_wen  out  1;  o_mem_ren  out  1;  i_mem_rd  in  32  memory-side port.

Function
REQ-014 The FSM SHALL have states IDLE, READ, WRITE, RMW_RD, RMW_WR; only IDLE accepts requests.
REQ-015 In IDLE, o_gnt_k SHALL assert combinationally in the same cycle as the accepted request; at that edge, we/addr/wd/be SHALL be latched with the requester id.
REQ-016 Arbitration, when both request with PRIO_FIXED=0: grant the requester indicated by a 1-bit pointer; the pointer SHALL toggle to the other requester after every grant; a lone requester SHALL always be granted.
REQ-017 Arbitration, with PRIO_FIXED=1: requester 0 SHALL win every conflict; the pointer SHALL be unused.
REQ-018 IDLE transitions: read -> READ; write with be=4'hF -> WRITE; write with be 4'h1..4'hE -> RMW_RD; write with be=4'h0 -> granted, no memory cycle, remain IDLE.
REQ-019 READ SHALL assert o_mem_ren, capture i_mem_rd into o_rdata of the owner, and return to IDLE; o_rvalid of the owner SHALL pulse in the following cycle (grant at cycle T -> rvalid at T+2).
REQ-020 WRITE SHALL assert o_mem_wen for exactly one cycle with o_mem_wd = latched wd, then return to IDLE.
REQ-021 RMW_RD SHALL assert o_mem_ren and capture i_mem_rd; RMW_WR SHALL assert o_mem_wen with merged data (lane n = wd lane if be[n], else captured lane), then return to IDLE; the write lands at T+2.
REQ-022 o_mem_ren and o_mem_wen SHALL never be high together, and both SHALL be 0 in IDLE.
REQ-023 o_mem_addr and o_mem_wd SHALL hold their last driven values outside access states.
REQ-024 o_rdata_k SHALL hold until the next read completed for requester k; rvalid SHALL go only to the originating requester; RMW reads SHALL NOT update o_rdata or pulse rvalid.
REQ-025 A new grant MAY occur in the same cycle as an rvalid pulse; throughput SHALL be 2 cycles per read or full write and 3 cycles per partial write.
REQ-026 Requests deasserted before grant SHALL be dropped without side effects.

Reset
REQ-027 i_rst_n=0 SHALL immediately force IDLE, set pointer to requester 0, and clear o_gnt*, o_rvalid*, o_mem_wen, o_mem_ren to 0 and o_rdata*, o_mem_addr, o_mem_wd to 0.
REQ-028 Reset during WRITE/RMW_WR SHALL drop o_mem_wen asynchronously; the aborted operation SHALL produce no rvalid and SHALL NOT be replayed.

Verification
REQ-029 Full write then read: req0 write addr 0x10, wd 0xDEADBEEF, be 4'hF -> one wen cycle; req0 read 0x10 -> rvalid0 two cycles after gnt0, o_rdata0 = memory word at 0x10.
REQ-030 Partial write: memory word 0x11223344, req1 write wd 0xAABBCCDD be 4'b0101 -> ren cycle then wen cycle with o_mem_wd 0x11BB33DD; no rvalid1.
REQ-031 Contention: both requesting continuously after reset, PRIO_FIXED=0 -> grants 0,1,0,1; PRIO_FIXED=1 -> grants 0,0,0.
REQ-032 Back-to-back: read then read from req0 -> second gnt0 coincides with first rvalid0; be=4'h0 write -> gnt only, no wen/ren.
REQ-033 Reset mid-RMW_WR -> o_mem_wen low before next edge, state IDLE, pointer 0, outputs zero, no rvalid.
REQ-034 Assertion on all runs: never o_mem_wen & o_mem_ren; never o_gnt0 & o_gnt1.
